// File: rtl/ifft4_pkg.sv
// Shared widths, rounding constants and saturation limits for the 4-point inverse FFT.
// The widths are derived from the time-domain sample width of the matching forward transform.
package ifft4_pkg;

  localparam int RND_CONST = 32'sd2;
  localparam int RND_SHIFT = 32'sd2;

  // Component width W.
  function automatic int comp_w(input int dw);
    return dw + 32'sd2;
  endfunction

  // Stage-1 butterfly width: W+1.
  function automatic int stage1_w(input int dw);
    return comp_w(dw) + 32'sd1;
  endfunction

  // Stage-2 unscaled width: W+3.
  function automatic int stage2_w(input int dw);
    return comp_w(dw) + 32'sd3;
  endfunction

  function automatic int sat_max(input int w);
    return (32'sd1 << (w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int sat_min(input int w);
    return -(32'sd1 << (w - 32'sd1));
  endfunction

endpackage

// File: rtl/ifft4_round_sat.sv
// Scales one stage-2 component by 1/4 with round-half-up, then clamps to W bits.
// The sat flag reports that the clamp engaged.
module ifft4_round_sat
  import ifft4_pkg::*;
#(
  parameter int W = 10
) (
  input  logic signed [W+2:0] v,
  output logic signed [W-1:0] y,
  output logic                sat
);

  // One spare bit so that adding the rounding constant can never wrap.
  localparam int WE = W + 4;
  localparam logic signed [WE-1:0] RND  = WE'(RND_CONST);
  localparam logic signed [WE-1:0] MAXV = WE'(sat_max(W));
  localparam logic signed [WE-1:0] MINV = WE'(sat_min(W));

  logic signed [WE-1:0] sum_s;
  logic signed [WE-1:0] shr_s;

  // Round, shift arithmetically, then clamp to the output range.
  always_comb begin
    sum_s = WE'(v) + RND;
    shr_s = sum_s >>> RND_SHIFT;
    if (shr_s > MAXV) begin
      y   = MAXV[W-1:0];
      sat = 1'b1;
    end else if (shr_s < MINV) begin
      y   = MINV[W-1:0];
      sat = 1'b1;
    end else begin
      y   = shr_s[W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/ifft4.sv
// Two-stage pipelined 4-point inverse FFT with valid/ready handshaking on both sides.
// Stage 1 registers the radix-2 butterflies; stage 2 combines, scales by 1/4 and saturates.
module ifft4
  import ifft4_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int W          = comp_w(DATA_WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in0_real,
  input  logic signed [W-1:0] in0_imag,
  input  logic signed [W-1:0] in1_real,
  input  logic signed [W-1:0] in1_imag,
  input  logic signed [W-1:0] in2_real,
  input  logic signed [W-1:0] in2_imag,
  input  logic signed [W-1:0] in3_real,
  input  logic signed [W-1:0] in3_imag,
  output logic signed [W-1:0] out0_real,
  output logic signed [W-1:0] out0_imag,
  output logic signed [W-1:0] out1_real,
  output logic signed [W-1:0] out1_imag,
  output logic signed [W-1:0] out2_real,
  output logic signed [W-1:0] out2_imag,
  output logic signed [W-1:0] out3_real,
  output logic signed [W-1:0] out3_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sat
);

  localparam int W1 = stage1_w(DATA_WIDTH);
  localparam int W3 = stage2_w(DATA_WIDTH);

  logic signed [W1-1:0] a_re_r, a_im_r, b_re_r, b_im_r;
  logic signed [W1-1:0] c_re_r, c_im_r, d_re_r, d_im_r;
  logic                 s1_valid_r;
  logic                 s2_valid_r;
  logic                 out_sat_r;
  logic                 adv1_s;
  logic                 adv2_s;
  logic signed [W3-1:0] v_s [8];
  logic signed [W-1:0]  y_s [8];
  logic signed [W-1:0]  y_r [8];
  logic [7:0]           sat_s;

  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid.
  assign adv2_s   = !s2_valid_r || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  // Stage 1: butterflies X0+-X2 and X1+-X3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      a_re_r <= '0; a_im_r <= '0; b_re_r <= '0; b_im_r <= '0;
      c_re_r <= '0; c_im_r <= '0; d_re_r <= '0; d_im_r <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        a_re_r <= W1'(in0_real) + W1'(in2_real);
        a_im_r <= W1'(in0_imag) + W1'(in2_imag);
        b_re_r <= W1'(in0_real) - W1'(in2_real);
        b_im_r <= W1'(in0_imag) - W1'(in2_imag);
        c_re_r <= W1'(in1_real) + W1'(in3_real);
        c_im_r <= W1'(in1_imag) + W1'(in3_imag);
        d_re_r <= W1'(in1_real) - W1'(in3_real);
        d_im_r <= W1'(in1_imag) - W1'(in3_imag);
      end
    end
  end

  // Multiplying d by +j swaps its parts and negates the new real part.
  assign v_s[0] = W3'(a_re_r) + W3'(c_re_r);
  assign v_s[1] = W3'(a_im_r) + W3'(c_im_r);
  assign v_s[2] = W3'(b_re_r) - W3'(d_im_r);
  assign v_s[3] = W3'(b_im_r) + W3'(d_re_r);
  assign v_s[4] = W3'(a_re_r) - W3'(c_re_r);
  assign v_s[5] = W3'(a_im_r) - W3'(c_im_r);
  assign v_s[6] = W3'(b_re_r) + W3'(d_im_r);
  assign v_s[7] = W3'(b_im_r) - W3'(d_re_r);

  for (genvar g = 0; g < 8; g++) begin : g_rs
    ifft4_round_sat #(.W(W)) u_rs (
      .v   (v_s[g]),
      .y   (y_s[g]),
      .sat (sat_s[g])
    );
  end

  // Stage 2: output frame register with its saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      out_sat_r  <= 1'b0;
      for (int i = 0; i < 8; i++) y_r[i] <= '0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        y_r       <= y_s;
        out_sat_r <= |sat_s;
      end
    end
  end

  assign out0_real = y_r[0];
  assign out0_imag = y_r[1];
  assign out1_real = y_r[2];
  assign out1_imag = y_r[3];
  assign out2_real = y_r[4];
  assign out2_imag = y_r[5];
  assign out3_real = y_r[6];
  assign out3_imag = y_r[7];
  assign out_valid = s2_valid_r;
  assign out_sat   = out_sat_r;

endmodule

// File: doc/ifft4.md
IFFT4 -- requirements
Module: ifft4

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, equal to the time-domain sample width of the matching forward transform.
REQ-002 SHALL use W = DATA_WIDTH+2 as the width of every input and output component.
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have in_valid, input, 1, meaning a frequency-domain frame is presented.
REQ-006 SHALL have in_ready, output, 1, meaning the block accepts the frame this cycle.
REQ-007 SHALL have in0_real..in3_real and in0_imag..in3_imag, input, W each, signed bins X0..X3.
REQ-008 SHALL have out0_real..out3_real and out0_imag..out3_imag, output, W each, signed samples x0..x3.
REQ-009 SHALL have out_valid, output, 1, meaning an output frame is held.
REQ-010 SHALL have out_ready, input, 1, meaning the sink takes the frame this cycle.
REQ-011 SHALL have out_sat, output, 1, meaning at least one component of the current output frame was saturated.

Function
REQ-012 SHALL compute x[n] = round(1/4 * sum over k of X[k]*W4^(-nk)), with W4^(-1) = +j.
REQ-013 Stage 1 SHALL register a = X0+X2, b = X0-X2, c = X1+X3, d = X1-X3, each at W+1 bits, sign-extended.
REQ-014 Stage 2 SHALL form the unscaled outputs at W+3 bits: x0 = a+c; x2 = a-c; x1 = (b_re-d_im, b_im+d_re); x3 = (b_re+d_im, b_im-d_re).
REQ-015 Stage 2 SHALL then round each component as (v+2)>>>2, arithmetic shift, round half toward +inf.
REQ-016 Stage 2 SHALL saturate each rounded component to [-2^(W-1), 2^(W-1)-1] before registering it.
REQ-017 out_sat SHALL be registered together with its frame, as the OR of the 8 per-component saturation events.
REQ-018 A frame SHALL be accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
REQ-019 Latency SHALL be 2 cycles: a frame accepted at edge N is presented with out_valid=1 after edge N+2 when there is no backpressure.
REQ-020 Throughput SHALL be one frame per cycle while out_ready=1.
REQ-021 Stall rules:
- adv2 = !s2_valid || out_ready.
- adv1 = !s1_valid || adv2.
- in_ready = adv1, combinational, with no combinational path from in_valid.
REQ-022 When adv2=0, outputs, out_valid and out_sat SHALL remain stable.
REQ-023 When adv1=0, stage-1 registers SHALL hold.
REQ-024 Frames SHALL never be dropped or duplicated.
REQ-025 Frame index order SHALL be preserved.
REQ-026 A simultaneous accept at the input and delivery at the output with both stages full SHALL advance both stages in the same cycle.
REQ-027 in_valid with in_ready=0 SHALL have no effect.
REQ-028 The input may change while it is not accepted.

Reset
REQ-029 Asserting rst SHALL immediately clear s1_valid, s2_valid, out_valid and out_sat.
REQ-030 Asserting rst SHALL immediately clear all data registers to 0, giving in_ready=1.
REQ-031 A reset mid-operation SHALL discard all in-flight frames.
REQ-032 The first frame accepted after deassertion SHALL appear exactly 2 cycles later.

Structure
REQ-033 Package ifft4_pkg SHALL hold the width function/constants (W, W+1, W+3), the rounding constant 2, and the saturation limits.
REQ-034 Sub-module ifft4_round_sat SHALL round and saturate one W+3-bit component to W bits plus a sat flag.
REQ-035 ifft4_round_sat SHALL be instantiated 8 times.

Verification (DATA_WIDTH=8, W=10)
REQ-036 Round-trip: X=(5,0),(2,1),(-5,0),(2,-1) -> x=(1,0),(2,0),(-1,0),(3,0) after 2 cycles, out_sat=0.
REQ-037 Rounding: X0=(2,0), others 0 -> all four outputs (1,0).
REQ-037a Rounding: X0=(1,0), others 0 -> all four outputs (0,0).
REQ-038 Saturation: X0re=511, X2re=-512, X1im=-512, X3im=511, all other components 0 -> out1_real=511 (unsaturated 512), out_sat=1.
REQ-039 Backpressure: out_ready=0, 3 frames offered -> 2 accepted, then in_ready=0.
REQ-039a Backpressure (cont.): outputs stay stable; after out_ready=1 all 3 frames exit in order on consecutive cycles.
REQ-040 Streaming: 8 back-to-back frames with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 2, values correct.
REQ-041 Reset mid-op: assert rst with both stages full -> out_valid=0 and in_ready=1 immediately.
REQ-041a Reset mid-op (cont.): after release, a new frame emerges 2 cycles after acceptance and no stale frame appears.
